// File: rtl/fourdemux_32_reg.sv
// fourdemux_32_reg: registered 1-to-4 demux with per-slot valid/ready; FOURDEMUX_32_CNT_EN adds per-slot drain counters
module fourdemux_32_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       S,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] QA,
  output logic [WIDTH-1:0] QB,
  output logic [WIDTH-1:0] QC,
  output logic [WIDTH-1:0] QD,
  output logic             VA,
  output logic             VB,
  output logic             VC,
  output logic             VD,
  input  logic             RA,
  input  logic             RB,
  input  logic             RC,
  input  logic             RD
`ifdef FOURDEMUX_32_CNT_EN
  ,
  output logic [CNT_W-1:0] CNTA,
  output logic [CNT_W-1:0] CNTB,
  output logic [CNT_W-1:0] CNTC,
  output logic [CNT_W-1:0] CNTD
`endif
);
  logic [3:0]       v_q, v_d, r;
  logic [WIDTH-1:0] q_q [4];
  logic [WIDTH-1:0] q_d [4];
  always_comb begin
    r = {RD, RC, RB, RA};
    IN_READY = !v_q[S] | r[S];
    for (int i = 0; i < 4; i++) begin
      q_d[i] = (IN_VALID && IN_READY && S == 2'(i)) ? D : q_q[i];
      v_d[i] = (IN_VALID && IN_READY && S == 2'(i)) | (v_q[i] & !r[i]);
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      v_q <= '0;
      q_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      q_q <= q_d;
    end
  end
  assign {VD, VC, VB, VA} = v_q;
  assign QA = q_q[0];
  assign QB = q_q[1];
  assign QC = q_q[2];
  assign QD = q_q[3];
`ifdef FOURDEMUX_32_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  always_comb begin
    for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i] + CNT_W'(v_q[i] & r[i]);
  end
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
  end
  assign CNTA = cnt_q[0];
  assign CNTB = cnt_q[1];
  assign CNTC = cnt_q[2];
  assign CNTD = cnt_q[3];
`endif
endmodule

// File: tb/tb_fourdemux_32_reg.sv
// tb_fourdemux_32_reg: directed self-checking bench for fourdemux_32_reg
module tb_fourdemux_32_reg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  logic             CLK = 0;
  logic             RST = 1;
  logic [WIDTH-1:0] D = '0;
  logic [1:0]       S = '0;
  logic             IN_VALID = 0;
  logic             IN_READY;
  logic [WIDTH-1:0] QA, QB, QC, QD;
  logic             VA, VB, VC, VD;
  logic             RA = 0, RB = 0, RC = 0, RD = 0;
`ifdef FOURDEMUX_32_CNT_EN
  logic [CNT_W-1:0] CNTA, CNTB, CNTC, CNTD;
`endif
  int checks = 0;
  int errors = 0;
  fourdemux_32_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .D(D), .S(S), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .QA(QA), .QB(QB), .QC(QC), .QD(QD),
    .VA(VA), .VB(VB), .VC(VC), .VD(VD),
    .RA(RA), .RB(RB), .RC(RC), .RD(RD)
`ifdef FOURDEMUX_32_CNT_EN
    , .CNTA(CNTA), .CNTB(CNTB), .CNTC(CNTC), .CNTD(CNTD)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset();
    RST = 1; IN_VALID = 1; D = 32'hFFFF_FFFF; S = 2;
    step();
    checks++;
    if ({VD, VC, VB, VA} !== 4'b0000) begin errors++; $display("FAIL reset_v1 got %b exp 0000", {VD, VC, VB, VA}); end
    step();
    checks++;
    if ({VD, VC, VB, VA} !== 4'b0000) begin errors++; $display("FAIL reset_v2 got %b exp 0000", {VD, VC, VB, VA}); end
    checks++;
    if ({QA, QB, QC, QD} !== 128'h0) begin errors++; $display("FAIL reset_q got %h exp 0", {QA, QB, QC, QD}); end
    RST = 0; IN_VALID = 0;
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", IN_READY); end
  endtask
  task automatic test_steering();
    logic [3:0] exp_v [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    {RD, RC, RB, RA} = 4'b1111;
    D = 32'hAAAA_AAAA;
    for (int i = 0; i < 5; i++) begin
      IN_VALID = (i < 4);
      S = 2'(i);
      step();
      checks++;
      if ({VD, VC, VB, VA} !== exp_v[i]) begin errors++; $display("FAIL steer_v%0d got %b exp %b", i, {VD, VC, VB, VA}, exp_v[i]); end
    end
    checks++;
    if ({QA, QB, QC, QD} !== {4{32'hAAAA_AAAA}}) begin errors++; $display("FAIL steer_q got %h exp all AAAAAAAA", {QA, QB, QC, QD}); end
  endtask
  task automatic test_backpressure();
    {RD, RC, RB, RA} = 4'b1101;
    IN_VALID = 1; S = 1; D = 32'h5555_5555;
    step();
    checks++;
    if (VB !== 1'b1 || QB !== 32'h5555_5555) begin errors++; $display("FAIL bp_load got VB=%b QB=%h exp 1 55555555", VB, QB); end
    D = 32'h1234_5678;
    #1;
    checks++;
    if (IN_READY !== 1'b0) begin errors++; $display("FAIL bp_stall got %b exp 0", IN_READY); end
    step();
    checks++;
    if (VB !== 1'b1 || QB !== 32'h5555_5555) begin errors++; $display("FAIL bp_hold got VB=%b QB=%h exp 1 55555555", VB, QB); end
    S = 3;
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL bp_resel got %b exp 1", IN_READY); end
    step();
    checks++;
    if (VD !== 1'b1 || QD !== 32'h1234_5678 || QB !== 32'h5555_5555) begin errors++; $display("FAIL bp_redirect got VD=%b QD=%h QB=%h exp 1 12345678 55555555", VD, QD, QB); end
    IN_VALID = 0; RB = 1;
    step();
    checks++;
    if ({VD, VC, VB, VA} !== 4'b0000) begin errors++; $display("FAIL bp_drain got %b exp 0000", {VD, VC, VB, VA}); end
  endtask
  task automatic test_drain_fill();
    {RD, RC, RB, RA} = 4'b0000;
    IN_VALID = 1; S = 2; D = 32'h0;
    step();
    checks++;
    if (VC !== 1'b1 || QC !== 32'h0) begin errors++; $display("FAIL df_fill got VC=%b QC=%h exp 1 0", VC, QC); end
    RC = 1; D = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL df_ready got %b exp 1", IN_READY); end
    step();
    checks++;
    if (VC !== 1'b1 || QC !== 32'hFFFF_FFFF) begin errors++; $display("FAIL df_swap got VC=%b QC=%h exp 1 FFFFFFFF", VC, QC); end
    IN_VALID = 0;
    step();
    checks++;
    if (VC !== 1'b0 || QC !== 32'hFFFF_FFFF) begin errors++; $display("FAIL df_empty got VC=%b QC=%h exp 0 FFFFFFFF", VC, QC); end
  endtask
  task automatic test_independent();
    {RD, RC, RB, RA} = 4'b0000;
    IN_VALID = 1;
    for (int i = 0; i < 4; i++) begin
      S = 2'(i); D = 32'(i + 1);
      step();
    end
    IN_VALID = 0;
    checks++;
    if ({VD, VC, VB, VA} !== 4'b1111) begin errors++; $display("FAIL ind_full got %b exp 1111", {VD, VC, VB, VA}); end
    RA = 1; RD = 1;
    step();
    checks++;
    if ({VD, VC, VB, VA} !== 4'b0110) begin errors++; $display("FAIL ind_drain got %b exp 0110", {VD, VC, VB, VA}); end
    checks++;
    if ({QA, QB, QC, QD} !== {32'h1, 32'h2, 32'h3, 32'h4}) begin errors++; $display("FAIL ind_q got %h exp 1 2 3 4", {QA, QB, QC, QD}); end
  endtask
  task automatic test_invalid();
    {RD, RC, RB, RA} = 4'b1111;
    step();
    IN_VALID = 0; S = 0; D = 32'hDEAD_BEEF;
    step();
    checks++;
    if (VA !== 1'b0 || QA !== 32'h1) begin errors++; $display("FAIL inv_noload got VA=%b QA=%h exp 0 1", VA, QA); end
  endtask
`ifdef FOURDEMUX_32_CNT_EN
  task automatic test_counter();
    RST = 1;
    step();
    RST = 0;
    {RD, RC, RB, RA} = 4'b1111;
    IN_VALID = 1; S = 0;
    for (int i = 0; i < 17; i++) begin
      D = 32'(i);
      step();
    end
    IN_VALID = 0;
    step();
    checks++;
    if (CNTA !== 4'd1) begin errors++; $display("FAIL cnt_wrap got %0d exp 1", CNTA); end
    checks++;
    if ({CNTB, CNTC, CNTD} !== 12'h0) begin errors++; $display("FAIL cnt_others got %h exp 0", {CNTB, CNTC, CNTD}); end
  endtask
`endif
  initial begin
    test_reset();
    test_steering();
    test_backpressure();
    test_drain_fill();
    test_independent();
    test_invalid();
`ifdef FOURDEMUX_32_CNT_EN
    test_counter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
